// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  function automatic int ndig_of(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must reach NDIG so it can also report a full-match digit count.
  function automatic int cnt_width_of(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/digit_comparator.sv
// Unsigned compare of one DIGIT-bit digit pair.
module digit_comparator #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (x == y);
  assign lt = (x < y);
  assign gt = (x > y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first
// differing digit; signed operands are compared in offset-binary form.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               signed_mode,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  output logic                               busy,
  output logic                               done,
  output logic                               equal,
  output logic                               lesser,
  output logic                               greater,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]   cycles
);

  localparam int NDIG = ndig_of(WIDTH, DIGIT);
  localparam int CW   = cnt_width_of(WIDTH, DIGIT);

  cmp_state_t       state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] msb_mask_s;
  logic             dig_eq_s;
  logic             dig_lt_s;
  logic             dig_gt_s;

  // Flipping both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    msb_mask_s            = '0;
    msb_mask_s[WIDTH-1]   = signed_mode;
  end

  digit_comparator #(.DIGIT(DIGIT)) u_digit (
    .x  (sa_r[WIDTH-1 -: DIGIT]),
    .y  (sb_r[WIDTH-1 -: DIGIT]),
    .eq (dig_eq_s),
    .lt (dig_lt_s),
    .gt (dig_gt_s)
  );

  // Control FSM, operand shift registers and registered result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      equal   <= 1'b0;
      lesser  <= 1'b0;
      greater <= 1'b0;
      cycles  <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa_r    <= a ^ msb_mask_s;
            sb_r    <= b ^ msb_mask_s;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (!dig_eq_s) begin
            equal   <= 1'b0;
            lesser  <= dig_lt_s;
            greater <= dig_gt_s;
            cycles  <= cnt_r + CW'(1);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else if (cnt_r == CW'(NDIG - 1)) begin
            equal   <= 1'b1;
            lesser  <= 1'b0;
            greater <= 1'b0;
            cycles  <= CW'(NDIG);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            sa_r    <= sa_r << DIGIT;
            sb_r    <= sb_r << DIGIT;
            cnt_r   <= cnt_r + CW'(1);
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: 16-bit/4-bit directed vectors plus a 4-bit/1-bit sweep.
module tb_serial_magnitude_comparator;

  typedef struct {
    int code;     // 0 equal, 1 lesser, 2 greater
    int cyc_n;
    int done_at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = 16'h0, b16 = 16'h0;
  logic        busy16, done16, eq16, lt16, gt16;
  logic [2:0]  cyc16;

  logic        start4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = 4'h0, b4 = 4'h0;
  logic        busy4, done4, eq4, lt4, gt4;
  logic [2:0]  cyc4;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;
  logic prev_done16 = 1'b0, prev_done4 = 1'b0;

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .equal(eq16), .lesser(lt16), .greater(gt16), .cycles(cyc16)
  );

  serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .equal(eq4), .lesser(lt4), .greater(gt4), .cycles(cyc4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int flags_of(input int code);
    case (code)
      0:       return 4;   // {equal, lesser, greater} = 100
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  // 16-bit monitor
  always @(negedge clk) begin
    if (rst_n && done16) begin
      chk("pulse16", int'(prev_done16), 0);
      if (q16.size() == 0) begin
        chk("spurious_done16", 1, 0);
      end else begin
        e16 = q16.pop_front();
        chk("flags16", int'({eq16, lt16, gt16}), flags_of(e16.code));
        chk("cycles16", int'(cyc16), e16.cyc_n);
        chk("latency16", cyc, e16.done_at);
      end
    end
    prev_done16 <= done16;
  end

  // 4-bit monitor
  always @(negedge clk) begin
    if (rst_n && done4) begin
      chk("pulse4", int'(prev_done4), 0);
      chk("onehot4", $countones({eq4, lt4, gt4}), 1);
      if (q4.size() == 0) begin
        chk("spurious_done4", 1, 0);
      end else begin
        e4 = q4.pop_front();
        chk("flags4", int'({eq4, lt4, gt4}), flags_of(e4.code));
        chk("cycles4", int'(cyc4), e4.cyc_n);
        chk("latency4", cyc, e4.done_at);
      end
    end
    prev_done4 <= done4;
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue16(input bit s, input logic [15:0] av, input logic [15:0] bv,
                         input int code, input int cn);
    exp_t e;
    start16 = 1'b1; sm16 = s; a16 = av; b16 = bv;
    e.code = code; e.cyc_n = cn; e.done_at = cyc + 1 + cn;
    q16.push_back(e);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5; sm16 = ~s;
  endtask

  task automatic issue4(input bit s, input logic [3:0] av, input logic [3:0] bv,
                        input int code, input int cn);
    exp_t e;
    start4 = 1'b1; sm4 = s; a4 = av; b4 = bv;
    e.code = code; e.cyc_n = cn; e.done_at = cyc + 1 + cn;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0; a4 = 4'h0; b4 = 4'hF;
  endtask

  task automatic drain16(input int budget);
    int n = 0;
    while (q16.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0) begin
      chk("timeout16", 1, 0);
      q16.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain4(input int budget);
    int n = 0;
    while (q4.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      chk("timeout4", 1, 0);
      q4.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] av, bv, x;
    int code, cn;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_flags", int'({eq16, lt16, gt16}), 0);
    chk("rst_cycles", int'(cyc16), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    issue16(1'b0, 16'h1234, 16'h1235, 1, 4); drain16(20);
    issue16(1'b0, 16'h9000, 16'h1FFF, 2, 1); drain16(20);
    issue16(1'b1, 16'h9000, 16'h1FFF, 1, 1); drain16(20);
    issue16(1'b1, 16'hFFFF, 16'h0000, 1, 1); drain16(20);
    issue16(1'b1, 16'h7FFF, 16'h8000, 2, 1); drain16(20);
    issue16(1'b1, 16'h8000, 16'h8001, 1, 4); drain16(20);
    issue16(1'b0, 16'h00F0, 16'h00E0, 2, 3); drain16(20);

    // Equal operands; a start while busy must be ignored
    issue16(1'b0, 16'hABCD, 16'hABCD, 0, 4);
    chk("busy_run", int'(busy16), 1);
    start16 = 1'b1; a16 = 16'h0000; b16 = 16'hABCD;
    @(negedge clk);
    start16 = 1'b0;
    drain16(20);

    // Back-to-back start in the DONE cycle; first result must hold
    issue16(1'b0, 16'h9000, 16'h1FFF, 2, 1);
    @(negedge clk);
    chk("done_b2b", int'(done16), 1);
    issue16(1'b0, 16'h0010, 16'h0020, 1, 3);
    for (int i = 0; i < 10 && q16.size() != 0; i++) begin
      if (!done16) chk("hold16", int'({eq16, lt16, gt16}), 1);
      @(negedge clk);
    end
    drain16(20);

    // Exhaustive 4-bit sweep in both modes
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          av = 4'(ai); bv = 4'(bi);
          if (av == bv) code = 0;
          else if (s == 1) code = ($signed(av) < $signed(bv)) ? 1 : 2;
          else code = (av < bv) ? 1 : 2;
          x = av ^ bv;
          cn = 4; found = 1'b0;
          for (int k = 3; k >= 0; k--) begin
            if (!found && x[k]) begin
              cn = 4 - k;
              found = 1'b1;
            end
          end
          issue4(s[0], av, bv, code, cn);
          drain4(12);
        end
      end
    end
    @(negedge clk);

    // Asynchronous reset aborts a comparison in flight
    issue16(1'b0, 16'h1234, 16'h1235, 1, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q16.delete();
    chk("arst_busy", int'(busy16), 0);
    chk("arst_done", int'(done16), 0);
    chk("arst_flags", int'({eq16, lt16, gt16}), 0);
    chk("arst_cycles", int'(cyc16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue16(1'b0, 16'h0001, 16'h0000, 2, 4);
    drain16(20);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator: compares two WIDTH-bit operands DIGIT bits per clock, MSB first, with early termination at the first differing digit.
- Adds signed/unsigned mode and a start/busy/done handshake.
- Shares the combinational compare path across cycles to save area in wide datapaths.
- Produces the same equal/lesser/greater result flags as the existing 4-bit combinational comparator.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a comparison; sampled only when busy=0
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- busy  output  1  comparison in progress
- done  output  1  one-cycle pulse: result flags valid and updated
- equal  output  1  A == B
- lesser  output  1  A < B
- greater  output  1  A > B
- cycles  output  $clog2(WIDTH/DIGIT+1)  number of digits examined for the last result

Behaviour:
- Reset (asynchronous, rst_n=0): busy=0, done=0, equal=0, lesser=0, greater=0, cycles=0, FSM=IDLE, shift registers cleared. The reset effect is immediate and aborts any comparison in flight.
- Constant: NDIG = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- IDLE, when start=1 at a clock edge:
  - capture a and b into shift registers sa and sb;
  - if signed_mode=1, invert the MSB of both captured operands (offset-binary), so the unsigned digit compare gives the signed order;
  - clear the digit counter; busy=1; go to RUN.
- RUN, each cycle: compare the top DIGIT bits of sa and sb.
  - If they differ: load lesser or greater per the digit compare (others 0); cycles = counter+1; go to DONE.
  - If they are equal and counter == NDIG-1: load equal=1 (others 0); cycles = NDIG; go to DONE.
  - Otherwise: shift sa and sb left by DIGIT, increment the counter, stay in RUN.
- DONE: done=1 and busy=0 for exactly one cycle; return to IDLE. A start asserted during the DONE cycle is accepted and is equivalent to start in IDLE (back-to-back operation).
- Latency: if the first differing digit index is d (0-based, MSB digit = 0), done is high in cycle start_edge + d + 2. A full match finishes at d = NDIG-1. Maximum latency is NDIG+1 cycles.
- Result flags and cycles update atomically on the edge entering DONE. They hold their value through later idle periods and new comparisons until the next DONE. After the first completion, exactly one of equal/lesser/greater is 1.
- start while busy=1 is ignored: no capture, no error.
- a, b and signed_mode are don't-care except on the start edge.
- DIGIT = WIDTH gives single-digit operation: latency 2, cycles always 1.

Decomposition:
- Shared package serial_cmp_pkg:
  - FSM state typedef (IDLE/RUN/DONE);
  - function computing NDIG and the counter width from WIDTH and DIGIT.
- One sub-module, digit_comparator: combinational, parametrised by DIGIT; outputs eq, lt, gt for one digit pair. The top level instantiates it once on the shift-register MSB slices.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
1. Reset: assert rst_n=0 mid-run, two cycles after start with a=0x1234, b=0x1235 -> busy, done, all flags and cycles go to 0 immediately. After release, a new start a=0x0001, b=0x0000 completes normally with greater=1.
2. Late difference: unsigned a=0x1234, b=0x1235 -> done in cycle start+5, lesser=1, cycles=4. Also a=0x9000, b=0x1FFF -> done in cycle start+2, greater=1, cycles=1.
3. Signed mode: signed_mode=1, a=0x9000, b=0x1FFF -> lesser=1. Also a=0xFFFF, b=0x0000 -> lesser=1, cycles=1. Also a=0x7FFF, b=0x8000 -> greater=1.
4. Equal and busy-ignore: a=b=0xABCD -> equal=1, cycles=4. A start with a=0x0000 asserted in cycle start+2 is ignored and the result is unchanged.
5. Back-to-back and hold: start held in the DONE cycle with new operands a=0x0010, b=0x0020 -> second result lesser=1, cycles=3. The first result's flags stay stable until the second done.
6. Exhaustive sweep: WIDTH=4, DIGIT=1, all 256 (a,b) pairs in both modes, checked against a behavioural model. Covers the flag one-hot property, cycles in range 1..4, and a done pulse width of exactly one cycle.
